dsky_relay_decoder: RTL and testbench
=====================================

DSKY_RELAY_DECODER -- requirements
Module: dsky_relay_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 64, is the number of consecutive identical samples required before a relay word is accepted (range 2..255).
REQ-002 SIM_CLK  input  1  system clock; every register updates on its rising edge.
REQ-003 SIM_RST  input  1  reset, synchronous, active-high.
REQ-004 RLYB01..RLYB11  input  1 each  relay data bits 1..11 from the AGC; 1 means the relay is energized.
REQ-005 RYWD12, RYWD13, RYWD14, RYWD16  input  1 each  relay row-select bits; together they form row[3:0] = {RYWD16,RYWD14,RYWD13,RYWD12}.
REQ-006 rd_digit  input  5  digit index for the read port.
REQ-007 rd_value  output  4  BCD value of the selected digit.
REQ-008 rd_blank  output  1  selected digit is blank.
REQ-009 rd_bad  output  1  selected digit holds an illegal relay code.
REQ-010 r1_sign, r2_sign, r3_sign  output  2 each  register sign as {plus,minus}.
REQ-011 flags  output  11  row-12 indicator bits 11..1.
REQ-012 upd_valid  output  1  one-cycle pulse on each committed row write.
REQ-013 upd_row  output  4  row number written; valid while upd_valid=1.
REQ-014 bad_row  output  1  one-cycle pulse when a word with row 13..15 is accepted.

Function
REQ-015 The block SHALL register the 15-bit word {row[3:0], RLYB11..RLYB01} once per cycle into a sample register.
REQ-016 The stability counter SHALL clear to 0 when the new sample differs from the previous sample, and otherwise SHALL increment, saturating at STABLE_CYCLES.
REQ-017 An accept SHALL occur in the single cycle where the counter reaches STABLE_CYCLES-1 and the sample is unchanged, so there is exactly one accept per stable period.
REQ-018 On accept with row 0, the block SHALL make no write and no pulse (blank/idle word).
REQ-019 On accept with row 1..12, the block SHALL write bits 11..1 into row register[row] and pulse upd_valid with upd_row=row in the following cycle.
REQ-020 On accept with row 13..15, the block SHALL write nothing and pulse bad_row in the following cycle.
REQ-021 Row field layout: bit 11 is the sign/flag bit, bits 10..6 are digit C, bits 5..1 are digit D.
REQ-022 Digit map (index: row.slot):
- 0-1 PROG: 11.C, 11.D
- 2-3 VERB: 10.C, 10.D
- 4-5 NOUN: 9.C, 9.D
- 6-10 R1: 8.D, 7.C, 7.D, 6.C, 6.D
- 11-15 R2: 5.C, 5.D, 4.C, 4.D, 3.C
- 16-20 R3: 3.D, 2.C, 2.D, 1.C, 1.D
REQ-023 Relay code decode (5-bit code to value):
- 00000 = blank
- 10101=0, 00011=1, 11001=2, 11011=3, 01111=4, 11110=5, 11100=6, 10011=7, 11101=8, 11111=9
REQ-024 An illegal code SHALL give rd_bad=1, rd_value=4'hF, rd_blank=0; blank SHALL give rd_blank=1, rd_value=0.
REQ-025 rd_digit 21..31 SHALL read as blank.
REQ-026 The read port SHALL be combinational from the row registers: a write is visible at rd_* in the same cycle as its upd_valid.
REQ-027 Sign bits: r1_sign = {row7.b11, row6.b11}, r2_sign = {row5.b11, row4.b11}, r3_sign = {row2.b11, row1.b11}.
REQ-028 flags SHALL equal row-12 register bits 11..1.
REQ-029 Latency: an input change at edge t, held steady, SHALL produce upd_valid at edge t+STABLE_CYCLES+1.

Reset
REQ-030 While SIM_RST=1, the block SHALL clear the sample register, counter, all 12 row registers, upd_valid, upd_row and bad_row to 0; all digits then read blank, signs 00, flags 0.
REQ-031 A reset mid-stability SHALL discard the pending word; after release, a full STABLE_CYCLES stable period is required before accept.

Verification
REQ-032 Reset, then drive row 11, C=11001, D=00011 held 70 cycles -> single upd_valid with upd_row=11 at cycle 65; rd_digit 0 reads 2, rd_digit 1 reads 1.
REQ-033 Toggle RLYB03 every 10 cycles for 500 cycles -> no upd_valid, all row registers unchanged.
REQ-034 Drive row 7, bit11=1, D=11111 held, then row 6, bit11=0 held -> r1_sign=10, rd_digit 8 reads 9.
REQ-035 Drive row 14 held 100 cycles -> exactly one bad_row pulse, no upd_valid; drive row 9, C=01010 -> rd_digit 4 gives rd_bad=1, rd_value=F.
REQ-036 Drive row 12, bits=11'h405 held -> flags=11'h405; then assert SIM_RST 1 cycle -> flags=0, all 21 digits blank.
REQ-037 Hold row 5 for 40 cycles, assert SIM_RST, release, hold row 5 for 64 more cycles -> upd_valid exactly 65 cycles after release.

Source files
------------

// File: rtl/dsky_relay_decoder.sv
// DSKY relay-word decoder: debounces the AGC relay word, latches rows 1..12
// and exposes a combinational BCD read port, register signs and indicator flags.
module dsky_relay_decoder #(
    parameter int STABLE_CYCLES = 64
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        RLYB01,
    input  logic        RLYB02,
    input  logic        RLYB03,
    input  logic        RLYB04,
    input  logic        RLYB05,
    input  logic        RLYB06,
    input  logic        RLYB07,
    input  logic        RLYB08,
    input  logic        RLYB09,
    input  logic        RLYB10,
    input  logic        RLYB11,
    input  logic        RYWD12,
    input  logic        RYWD13,
    input  logic        RYWD14,
    input  logic        RYWD16,
    input  logic [4:0]  rd_digit,
    output logic [3:0]  rd_value,
    output logic        rd_blank,
    output logic        rd_bad,
    output logic [1:0]  r1_sign,
    output logic [1:0]  r2_sign,
    output logic [1:0]  r3_sign,
    output logic [10:0] flags,
    output logic        upd_valid,
    output logic [3:0]  upd_row,
    output logic        bad_row
);

    localparam logic [7:0] SAT_C    = 8'(STABLE_CYCLES);
    localparam logic [7:0] ACCEPT_C = 8'(STABLE_CYCLES - 1);

    // Relay code to {bad, blank, value}; anything not in the table is illegal.
    function automatic logic [5:0] decode_relay(input logic [4:0] code);
        logic [5:0] res;
        case (code)
            5'b00000: res = {1'b0, 1'b1, 4'd0};
            5'b10101: res = {1'b0, 1'b0, 4'd0};
            5'b00011: res = {1'b0, 1'b0, 4'd1};
            5'b11001: res = {1'b0, 1'b0, 4'd2};
            5'b11011: res = {1'b0, 1'b0, 4'd3};
            5'b01111: res = {1'b0, 1'b0, 4'd4};
            5'b11110: res = {1'b0, 1'b0, 4'd5};
            5'b11100: res = {1'b0, 1'b0, 4'd6};
            5'b10011: res = {1'b0, 1'b0, 4'd7};
            5'b11101: res = {1'b0, 1'b0, 4'd8};
            5'b11111: res = {1'b0, 1'b0, 4'd9};
            default:  res = {1'b1, 1'b0, 4'hF};
        endcase
        return res;
    endfunction

    logic [14:0] word_s;
    logic [14:0] sample_r;
    logic [7:0]  cnt_r;
    logic        same_s;
    logic        accept_s;
    logic        acc_r;
    logic [14:0] acc_word_r;
    logic [3:0]  acc_row_s;
    logic        row_ok_s;
    logic        row_bad_s;
    logic [10:0] rows_r [1:12];
    logic [4:0]  code_s;
    logic [5:0]  dec_s;

    assign word_s = {RYWD16, RYWD14, RYWD13, RYWD12,
                     RLYB11, RLYB10, RLYB09, RLYB08, RLYB07, RLYB06,
                     RLYB05, RLYB04, RLYB03, RLYB02, RLYB01};

    // Stability detection and accept qualification.
    always_comb begin
        same_s    = (word_s == sample_r);
        accept_s  = same_s && (cnt_r == ACCEPT_C);
        acc_row_s = acc_word_r[14:11];
        row_ok_s  = (acc_row_s >= 4'd1) && (acc_row_s <= 4'd12);
        row_bad_s = (acc_row_s >= 4'd13);
    end

    // Sample register, saturating stability counter and one-deep accept stage.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            sample_r   <= 15'd0;
            cnt_r      <= 8'd0;
            acc_r      <= 1'b0;
            acc_word_r <= 15'd0;
        end else begin
            sample_r   <= word_s;
            acc_r      <= accept_s;
            acc_word_r <= sample_r;
            if (!same_s) begin
                cnt_r <= 8'd0;
            end else if (cnt_r != SAT_C) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Row register write and the one-cycle update / bad-row pulses.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            for (int i = 1; i <= 12; i++) begin
                rows_r[i] <= 11'd0;
            end
            upd_valid <= 1'b0;
            upd_row   <= 4'd0;
            bad_row   <= 1'b0;
        end else begin
            for (int i = 1; i <= 12; i++) begin
                if (acc_r && row_ok_s && (acc_row_s == 4'(i))) begin
                    rows_r[i] <= acc_word_r[10:0];
                end else begin
                    rows_r[i] <= rows_r[i];
                end
            end
            upd_valid <= acc_r && row_ok_s;
            upd_row   <= (acc_r && row_ok_s) ? acc_row_s : 4'd0;
            bad_row   <= acc_r && row_bad_s;
        end
    end

    // Digit index to relay code; C is stored in [9:5], D in [4:0].
    always_comb begin
        code_s = 5'b00000;
        case (rd_digit)
            5'd0:    code_s = rows_r[11][9:5];
            5'd1:    code_s = rows_r[11][4:0];
            5'd2:    code_s = rows_r[10][9:5];
            5'd3:    code_s = rows_r[10][4:0];
            5'd4:    code_s = rows_r[9][9:5];
            5'd5:    code_s = rows_r[9][4:0];
            5'd6:    code_s = rows_r[8][4:0];
            5'd7:    code_s = rows_r[7][9:5];
            5'd8:    code_s = rows_r[7][4:0];
            5'd9:    code_s = rows_r[6][9:5];
            5'd10:   code_s = rows_r[6][4:0];
            5'd11:   code_s = rows_r[5][9:5];
            5'd12:   code_s = rows_r[5][4:0];
            5'd13:   code_s = rows_r[4][9:5];
            5'd14:   code_s = rows_r[4][4:0];
            5'd15:   code_s = rows_r[3][9:5];
            5'd16:   code_s = rows_r[3][4:0];
            5'd17:   code_s = rows_r[2][9:5];
            5'd18:   code_s = rows_r[2][4:0];
            5'd19:   code_s = rows_r[1][9:5];
            5'd20:   code_s = rows_r[1][4:0];
            default: code_s = 5'b00000;
        endcase
        dec_s = decode_relay(code_s);
    end

    assign rd_bad   = dec_s[5];
    assign rd_blank = dec_s[4];
    assign rd_value = dec_s[3:0];
    assign r1_sign  = {rows_r[7][10], rows_r[6][10]};
    assign r2_sign  = {rows_r[5][10], rows_r[4][10]};
    assign r3_sign  = {rows_r[2][10], rows_r[1][10]};
    assign flags    = rows_r[12];

endmodule

// File: tb/tb_dsky_relay_decoder.sv
// Bench for dsky_relay_decoder: directed scenarios plus random relay words,
// checked every cycle against a run-length reference model.
module tb_dsky_relay_decoder;
    localparam int S = 64;

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST = 1'b1;
    logic [14:0] in_word = 15'd0;
    logic [4:0]  rd_digit = 5'd0;
    logic [3:0]  rd_value;
    logic        rd_blank, rd_bad, upd_valid, bad_row;
    logic [1:0]  r1_sign, r2_sign, r3_sign;
    logic [10:0] flags;
    logic [3:0]  upd_row;

    int checks = 0, errors = 0;
    int edge_n = 0, upd_count = 0, bad_count = 0, last_upd_edge = -1, t0 = 0;

    // Reference model state
    logic [10:0] m_rows [1:12];
    logic [14:0] m_prev = 15'd0;
    int          m_run = 1;
    logic        m_pend = 1'b0;
    logic [14:0] m_pend_word = 15'd0;
    logic        e_upd, e_bad;
    logic [3:0]  e_row;

    int         dig_row [21] = '{11, 11, 10, 10, 9, 9, 8, 7, 7, 6, 6, 5, 5, 4, 4, 3, 3, 2, 2, 1, 1};
    bit         dig_c   [21] = '{1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    logic [4:0] codes   [10] = '{5'b10101, 5'b00011, 5'b11001, 5'b11011, 5'b01111,
                                 5'b11110, 5'b11100, 5'b10011, 5'b11101, 5'b11111};

    dsky_relay_decoder #(.STABLE_CYCLES(S)) dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
        .RLYB01(in_word[0]), .RLYB02(in_word[1]), .RLYB03(in_word[2]), .RLYB04(in_word[3]),
        .RLYB05(in_word[4]), .RLYB06(in_word[5]), .RLYB07(in_word[6]), .RLYB08(in_word[7]),
        .RLYB09(in_word[8]), .RLYB10(in_word[9]), .RLYB11(in_word[10]),
        .RYWD12(in_word[11]), .RYWD13(in_word[12]), .RYWD14(in_word[13]), .RYWD16(in_word[14]),
        .rd_digit(rd_digit), .rd_value(rd_value), .rd_blank(rd_blank), .rd_bad(rd_bad),
        .r1_sign(r1_sign), .r2_sign(r2_sign), .r3_sign(r3_sign), .flags(flags),
        .upd_valid(upd_valid), .upd_row(upd_row), .bad_row(bad_row)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A word is accepted once it has been seen on S+1 consecutive edges; its effect lands one edge later.
    task automatic model_edge();
        int r;
        e_upd = 1'b0;
        e_bad = 1'b0;
        e_row = 4'd0;
        if (SIM_RST) begin
            for (int i = 1; i <= 12; i++) m_rows[i] = 11'd0;
            m_pend = 1'b0;
            m_prev = 15'd0;
            m_run  = 1;
        end else begin
            if (m_pend) begin
                r = int'(m_pend_word[14:11]);
                if (r >= 1 && r <= 12) begin
                    m_rows[r] = m_pend_word[10:0];
                    e_upd = 1'b1;
                    e_row = 4'(r);
                end else if (r >= 13) begin
                    e_bad = 1'b1;
                end
                m_pend = 1'b0;
            end
            if (in_word == m_prev) m_run++;
            else m_run = 1;
            m_prev = in_word;
            if (m_run == S + 1) begin
                m_pend = 1'b1;
                m_pend_word = in_word;
            end
        end
    endtask

    // Expected {bad, blank, value} for a digit index, from the model rows.
    function automatic logic [5:0] exp_read(input int d);
        logic [4:0] code;
        if (d > 20) return {1'b0, 1'b1, 4'd0};
        code = dig_c[d] ? m_rows[dig_row[d]][9:5] : m_rows[dig_row[d]][4:0];
        if (code == 5'd0) return {1'b0, 1'b1, 4'd0};
        for (int k = 0; k < 10; k++) begin
            if (codes[k] == code) return {1'b0, 1'b0, 4'(k)};
        end
        return {1'b1, 1'b0, 4'hF};
    endfunction

    task automatic cycle();
        @(posedge SIM_CLK);
        edge_n++;
        model_edge();
        #1;
        if (upd_valid === 1'b1) begin
            upd_count++;
            last_upd_edge = edge_n;
        end
        if (bad_row === 1'b1) bad_count++;
        check("upd_valid", 32'(upd_valid), 32'(e_upd));
        check("bad_row", 32'(bad_row), 32'(e_bad));
        if (e_upd) check("upd_row", 32'(upd_row), 32'(e_row));
        check("read_port", 32'({rd_bad, rd_blank, rd_value}), 32'(exp_read(int'(rd_digit))));
        check("flags", 32'(flags), 32'(m_rows[12]));
        check("signs", 32'({r1_sign, r2_sign, r3_sign}),
              32'({m_rows[7][10], m_rows[6][10], m_rows[5][10], m_rows[4][10],
                   m_rows[2][10], m_rows[1][10]}));
        rd_digit = 5'($urandom_range(0, 31));
    endtask

    task automatic hold(input int n);
        repeat (n) cycle();
    endtask

    task automatic all_blank(input string tag);
        for (int d = 0; d < 32; d++) begin
            rd_digit = 5'(d);
            #1;
            check(tag, 32'({rd_bad, rd_blank, rd_value}), 32'({1'b0, 1'b1, 4'd0}));
        end
    endtask

    initial begin
        logic [4:0] c_code, d_code;
        for (int i = 1; i <= 12; i++) m_rows[i] = 11'd0;

        // Reset state
        SIM_RST = 1'b1;
        hold(3);
        all_blank("reset_blank");
        check("reset_flags", 32'(flags), 32'd0);

        // Row 11 PROG = 21, latency S+1 from first sampled edge
        SIM_RST = 1'b0;
        in_word = {4'd11, 1'b0, 5'b11001, 5'b00011};
        upd_count = 0;
        t0 = edge_n + 1;
        hold(70);
        check("prog_upd_count", 32'(upd_count), 32'd1);
        check("prog_latency", 32'(last_upd_edge - t0), 32'(S + 1));
        rd_digit = 5'd0; #1;
        check("prog_d0", 32'({rd_bad, rd_blank, rd_value}), 32'({1'b0, 1'b0, 4'd2}));
        rd_digit = 5'd1; #1;
        check("prog_d1", 32'({rd_bad, rd_blank, rd_value}), 32'({1'b0, 1'b0, 4'd1}));

        // Chattering bit never settles long enough
        upd_count = 0;
        for (int i = 0; i < 50; i++) begin
            in_word = in_word ^ 15'h0004;
            hold(10);
        end
        check("chatter_no_upd", 32'(upd_count), 32'd0);
        rd_digit = 5'd0; #1;
        check("chatter_keep", 32'(rd_value), 32'd2);

        // R1 sign and digit
        in_word = {4'd7, 1'b1, 5'b10101, 5'b11111};
        hold(70);
        in_word = {4'd6, 1'b0, 5'b00011, 5'b10101};
        hold(70);
        check("r1_sign", 32'(r1_sign), 32'(2'b10));
        rd_digit = 5'd8; #1;
        check("r1_d8", 32'({rd_bad, rd_blank, rd_value}), 32'({1'b0, 1'b0, 4'd9}));

        // Illegal row, then illegal code
        upd_count = 0;
        bad_count = 0;
        in_word = {4'd14, 11'h2AB};
        hold(100);
        check("badrow_count", 32'(bad_count), 32'd1);
        check("badrow_no_upd", 32'(upd_count), 32'd0);
        in_word = {4'd9, 1'b0, 5'b01010, 5'b00011};
        hold(70);
        rd_digit = 5'd4; #1;
        check("illegal_code", 32'({rd_bad, rd_blank, rd_value}), 32'({1'b1, 1'b0, 4'hF}));

        // Flags row and single-cycle reset
        in_word = {4'd12, 11'h405};
        hold(70);
        check("flags_405", 32'(flags), 32'h405);
        SIM_RST = 1'b1;
        cycle();
        SIM_RST = 1'b0;
        check("flags_cleared", 32'(flags), 32'd0);
        all_blank("post_reset_blank");

        // Reset mid-stability discards the pending word
        in_word = {4'd5, 1'b0, 5'b11110, 5'b11100};
        hold(40);
        SIM_RST = 1'b1;
        cycle();
        SIM_RST = 1'b0;
        upd_count = 0;
        t0 = edge_n + 1;
        hold(70);
        check("rst_mid_count", 32'(upd_count), 32'd1);
        check("rst_mid_latency", 32'(last_upd_edge - t0), 32'(S + 1));

        // Random words, hold lengths around the stability boundary, occasional reset
        for (int n = 0; n < 40; n++) begin
            c_code = ($urandom_range(0, 4) == 0) ? 5'($urandom) : codes[$urandom_range(0, 9)];
            d_code = ($urandom_range(0, 4) == 0) ? 5'($urandom) : codes[$urandom_range(0, 9)];
            in_word = {4'($urandom_range(0, 15)), 1'($urandom), c_code, d_code};
            case ($urandom_range(0, 3))
                0:       hold($urandom_range(1, 30));
                1:       hold($urandom_range(S - 1, S + 2));
                default: hold($urandom_range(S + 3, S + 12));
            endcase
            if ($urandom_range(0, 9) == 0) begin
                SIM_RST = 1'b1;
                cycle();
                SIM_RST = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
